return_addr_stack: RTL and testbench

RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

---
 rtl/return_addr_stack_pkg.sv | 33 +++
 rtl/return_addr_stack_ras_ptr.sv | 76 +++++++
 rtl/return_addr_stack.sv | 139 +++++++++++++
 tb/tb_return_addr_stack.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/return_addr_stack_pkg.sv
// Shared frontend package: opcode constants, link-register helpers and
// return-address-stack sizing/link constants used by the RAS block.
package return_addr_stack_pkg;

  // Major opcodes recognised by the pre-decoder for call/return detection.
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  // A call links to the instruction following it (uncompressed, 4 bytes).
  localparam logic [31:0] RAS_LINK_OFFSET = 32'd4;

  // Default stack depth; must be a power of two and at least 2.
  localparam int RAS_DEPTH_DEFAULT = 8;

  // Operation applied to the speculative stack in a given cycle.
  typedef enum logic [1:0] {
    RAS_OP_NONE    = 2'd0,
    RAS_OP_PUSH    = 2'd1,
    RAS_OP_POP     = 2'd2,
    RAS_OP_REPLACE = 2'd3
  } ras_op_e;

  // Pointer width for a stack of the given depth.
  function automatic int ras_ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // x1 (ra) and x5 (t0) are the architectural link registers.
  function automatic logic is_link_reg(input logic [4:0] reg_idx);
    return (reg_idx == 5'd1) || (reg_idx == 5'd5);
  endfunction

endpackage

// File: rtl/return_addr_stack_ras_ptr.sv
// Circular stack pointer plus saturating occupancy count. The optional load
// replaces the current pair as the base before push/pop is applied, which
// lets the speculative copy resynchronise to the committed copy including a
// commit happening in the same cycle.
module ras_ptr
  import return_addr_stack_pkg::*;
#(
  parameter  int DEPTH = RAS_DEPTH_DEFAULT,
  localparam int PTR_W = ras_ptr_w(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [PTR_W-1:0] load_sp,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] sp,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [PTR_W-1:0] sp_r;
  logic [CNT_W-1:0] cnt_r;
  logic [PTR_W-1:0] base_sp_s;
  logic [CNT_W-1:0] base_cnt_s;
  logic [PTR_W-1:0] sp_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Next pointer/count: pick the base, then apply push (saturating) or pop (guarded).
  always_comb begin
    base_sp_s  = sp_r;
    base_cnt_s = cnt_r;
    if (load) begin
      base_sp_s  = load_sp;
      base_cnt_s = load_cnt;
    end else begin
      base_sp_s  = sp_r;
      base_cnt_s = cnt_r;
    end

    sp_nxt_s  = base_sp_s;
    cnt_nxt_s = base_cnt_s;
    if (push && !pop) begin
      sp_nxt_s = base_sp_s + PTR_W'(1);
      if (base_cnt_s != CNT_MAX) begin
        cnt_nxt_s = base_cnt_s + CNT_W'(1);
      end else begin
        cnt_nxt_s = base_cnt_s;
      end
    end else if (pop && !push && (base_cnt_s != {CNT_W{1'b0}})) begin
      sp_nxt_s  = base_sp_s - PTR_W'(1);
      cnt_nxt_s = base_cnt_s - CNT_W'(1);
    end else begin
      sp_nxt_s  = base_sp_s;
      cnt_nxt_s = base_cnt_s;
    end
  end

  // Pointer/count state register with asynchronous reset to an empty stack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_r  <= {PTR_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      sp_r  <= sp_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  assign sp  = sp_r;
  assign cnt = cnt_r;

endmodule

// File: rtl/return_addr_stack.sv
// Return address stack fed by the pre-decoder. A speculative pointer/count
// drives same-cycle return prediction; a committed pointer/count follows the
// retire stream and is copied back into the speculative one on flush. The
// storage itself is shared and never rewritten by flush.
module return_addr_stack
  import return_addr_stack_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = RAS_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pdec_valid,
  input  logic                  pdec_call,
  input  logic                  pdec_ret,
  input  logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  commit_call,
  input  logic                  commit_ret,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] ras_target,
  output logic                  ras_hit,
  output logic                  ras_empty,
  output logic                  ras_full
);

  localparam int PTR_W = ras_ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] entry_r [DEPTH];

  logic [PTR_W-1:0]      spec_sp_s;
  logic [CNT_W-1:0]      spec_cnt_s;
  logic [PTR_W-1:0]      cmt_sp_s;
  logic [CNT_W-1:0]      cmt_cnt_s;

  ras_op_e               op_s;
  logic                  empty_s;
  logic                  spec_push_s;
  logic                  spec_pop_s;
  logic                  wr_en_s;
  logic [PTR_W-1:0]      wr_addr_s;
  logic [PTR_W-1:0]      top_addr_s;
  logic [ADDR_WIDTH-1:0] link_s;

  assign empty_s    = (spec_cnt_s == {CNT_W{1'b0}});
  assign top_addr_s = spec_sp_s - PTR_W'(1);
  assign link_s     = inst_pc + ADDR_WIDTH'(RAS_LINK_OFFSET);

  // Classify this cycle's pre-decode activity; flush suppresses it entirely.
  always_comb begin
    op_s = RAS_OP_NONE;
    if (flush) begin
      op_s = RAS_OP_NONE;
    end else if (pdec_valid) begin
      case ({pdec_call, pdec_ret})
        2'b11:   op_s = empty_s ? RAS_OP_PUSH : RAS_OP_REPLACE;
        2'b10:   op_s = RAS_OP_PUSH;
        2'b01:   op_s = RAS_OP_POP;
        default: op_s = RAS_OP_NONE;
      endcase
    end else begin
      op_s = RAS_OP_NONE;
    end
  end

  // On flush the speculative pair loads the committed pair and replays this cycle's commit.
  always_comb begin
    spec_push_s = 1'b0;
    spec_pop_s  = 1'b0;
    if (flush) begin
      spec_push_s = commit_call;
      spec_pop_s  = commit_ret;
    end else begin
      spec_push_s = (op_s == RAS_OP_PUSH);
      spec_pop_s  = (op_s == RAS_OP_POP);
    end
  end

  // Storage write port: a push fills the slot at the pointer, a replace rewrites the top.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = spec_sp_s;
    case (op_s)
      RAS_OP_PUSH: begin
        wr_en_s   = 1'b1;
        wr_addr_s = spec_sp_s;
      end
      RAS_OP_REPLACE: begin
        wr_en_s   = 1'b1;
        wr_addr_s = top_addr_s;
      end
      default: begin
        wr_en_s   = 1'b0;
        wr_addr_s = spec_sp_s;
      end
    endcase
  end

  ras_ptr #(.DEPTH(DEPTH)) u_spec_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (flush),
    .load_sp  (cmt_sp_s),
    .load_cnt (cmt_cnt_s),
    .push     (spec_push_s),
    .pop      (spec_pop_s),
    .sp       (spec_sp_s),
    .cnt      (spec_cnt_s)
  );

  ras_ptr #(.DEPTH(DEPTH)) u_cmt_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_sp  ({PTR_W{1'b0}}),
    .load_cnt ({CNT_W{1'b0}}),
    .push     (commit_call),
    .pop      (commit_ret),
    .sp       (cmt_sp_s),
    .cnt      (cmt_cnt_s)
  );

  // Return-address storage; cleared on reset, written only by speculative push/replace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= {ADDR_WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      entry_r[wr_addr_s] <= link_s;
    end
  end

  assign ras_target = empty_s ? {ADDR_WIDTH{1'b0}} : entry_r[top_addr_s];
  assign ras_hit    = pdec_valid & pdec_ret & ~empty_s;
  assign ras_empty  = empty_s;
  assign ras_full   = (spec_cnt_s == CNT_W'(DEPTH));

endmodule

// File: tb/tb_return_addr_stack.sv
// Self-checking bench for return_addr_stack: directed scenarios plus a short
// randomised run against a behavioural stack model, with expected targets
// queued when stimulus is applied and popped at the comparison point.
module tb_return_addr_stack;

  localparam int AW = 32;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          pdec_valid, pdec_call, pdec_ret;
  logic [AW-1:0] inst_pc;
  logic          commit_call, commit_ret, flush;
  logic [AW-1:0] ras_target;
  logic          ras_hit, ras_empty, ras_full;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] exp_v;

  // Behavioural model state for the random scenario.
  logic [AW-1:0] m_ent [D];
  logic [2:0]    m_sp, c_sp;
  logic [3:0]    m_cnt, c_cnt;

  return_addr_stack #(.ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .pdec_valid  (pdec_valid),
    .pdec_call   (pdec_call),
    .pdec_ret    (pdec_ret),
    .inst_pc     (inst_pc),
    .commit_call (commit_call),
    .commit_ret  (commit_ret),
    .flush       (flush),
    .ras_target  (ras_target),
    .ras_hit     (ras_hit),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full)
  );

  always #5 clk = ~clk;

  task automatic clr();
    pdec_valid  = 1'b0;
    pdec_call   = 1'b0;
    pdec_ret    = 1'b0;
    inst_pc     = 32'h0;
    commit_call = 1'b0;
    commit_ret  = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic set_in(input logic v, input logic c, input logic r, input logic [AW-1:0] pc);
    pdec_valid = v;
    pdec_call  = c;
    pdec_ret   = r;
    inst_pc    = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic push_call(input logic [AW-1:0] pc);
    set_in(1'b1, 1'b1, 1'b0, pc);
    tick();
    clr();
  endtask

  task automatic test_reset();
    clr();
    @(negedge clk);
    rst = 1'b1;
    set_in(1'b1, 1'b0, 1'b1, 32'h0);
    #2;
    tests_run++;
    if (ras_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b want 1", ras_empty); end
    tests_run++;
    if (ras_full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b want 0", ras_full); end
    tests_run++;
    if (ras_target !== 32'h0) begin tests_failed++; $display("FAIL reset_target: got %h want 0", ras_target); end
    tests_run++;
    if (ras_hit !== 1'b0) begin tests_failed++; $display("FAIL reset_hit: got %b want 0", ras_hit); end
    tick();
    rst = 1'b0;
    clr();
    tick();
  endtask

  task automatic test_push_pop();
    do_reset();
    for (int k = 1; k <= 3; k++) push_call(32'h100 * k);
    #1;
    exp_q.push_back(32'h304);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (ras_target !== exp_v) begin tests_failed++; $display("FAIL pp_top: got %h want %h", ras_target, exp_v); end
    exp_q.push_back(32'h304);
    exp_q.push_back(32'h204);
    exp_q.push_back(32'h104);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 1'b1, 32'h0);
      #1;
      exp_v = exp_q.pop_front();
      tests_run++;
      if (ras_target !== exp_v) begin tests_failed++; $display("FAIL pp_pop%0d: got %h want %h", i, ras_target, exp_v); end
      tests_run++;
      if (ras_hit !== 1'b1) begin tests_failed++; $display("FAIL pp_hit%0d: got %b want 1", i, ras_hit); end
      tick();
    end
    clr();
    #1;
    tests_run++;
    if (ras_empty !== 1'b1) begin tests_failed++; $display("FAIL pp_empty: got %b want 1", ras_empty); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k <= 8; k++) push_call(32'h1000 + 32'h10 * k);
    #1;
    tests_run++;
    if (ras_full !== 1'b1) begin tests_failed++; $display("FAIL ovf_full: got %b want 1", ras_full); end
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h1084 - 32'h10 * i);
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 1'b0, 1'b1, 32'h0);
      #1;
      exp_v = exp_q.pop_front();
      tests_run++;
      if (ras_target !== exp_v) begin tests_failed++; $display("FAIL ovf_pop%0d: got %h want %h", i, ras_target, exp_v); end
      tick();
    end
    set_in(1'b1, 1'b0, 1'b1, 32'h0);
    #1;
    tests_run++;
    if (ras_hit !== 1'b0) begin tests_failed++; $display("FAIL ovf_underflow_hit: got %b want 0", ras_hit); end
    tests_run++;
    if (ras_target !== 32'h0) begin tests_failed++; $display("FAIL ovf_underflow_target: got %h want 0", ras_target); end
    tick();
    clr();
    #1;
    tests_run++;
    if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
      tests_failed++; $display("FAIL ovf_after_underflow: empty %b full %b want 1 0", ras_empty, ras_full);
    end
  endtask

  task automatic test_flush();
    do_reset();
    push_call(32'h100);
    push_call(32'h200);
    commit_call = 1'b1;
    tick();
    tick();
    clr();
    push_call(32'h300);
    push_call(32'h400);
    push_call(32'h500);
    #1;
    tests_run++;
    if (ras_target !== 32'h504) begin tests_failed++; $display("FAIL fl_pre: got %h want 00000504", ras_target); end
    flush = 1'b1;
    tick();
    clr();
    #1;
    exp_q.push_back(32'h204);
    exp_q.push_back(32'h104);
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b0, 1'b1, 32'h0);
      #1;
      exp_v = exp_q.pop_front();
      tests_run++;
      if (ras_target !== exp_v) begin tests_failed++; $display("FAIL fl_pop%0d: got %h want %h", i, ras_target, exp_v); end
      tick();
    end
    clr();
    #1;
    tests_run++;
    if (ras_empty !== 1'b1) begin tests_failed++; $display("FAIL fl_empty: got %b want 1", ras_empty); end
  endtask

  task automatic test_flush_commit();
    do_reset();
    push_call(32'h100);
    commit_call = 1'b1;
    tick();
    clr();
    push_call(32'h200);
    flush       = 1'b1;
    commit_call = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 32'h900);
    tick();
    clr();
    #1;
    exp_q.push_back(32'h204);
    exp_q.push_back(32'h104);
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b0, 1'b1, 32'h0);
      #1;
      exp_v = exp_q.pop_front();
      tests_run++;
      if (ras_target !== exp_v) begin tests_failed++; $display("FAIL fc_pop%0d: got %h want %h", i, ras_target, exp_v); end
      tests_run++;
      if (ras_empty !== 1'b0) begin tests_failed++; $display("FAIL fc_nonempty%0d: got %b want 0", i, ras_empty); end
      tick();
    end
    clr();
    #1;
    tests_run++;
    if (ras_empty !== 1'b1) begin tests_failed++; $display("FAIL fc_empty: got %b want 1", ras_empty); end
  endtask

  task automatic test_replace();
    do_reset();
    push_call(32'h100);
    push_call(32'h200);
    set_in(1'b1, 1'b1, 1'b1, 32'h400);
    #1;
    tests_run++;
    if (ras_target !== 32'h204 || ras_hit !== 1'b1) begin
      tests_failed++; $display("FAIL rp_pred: target %h hit %b want 00000204 1", ras_target, ras_hit);
    end
    tick();
    clr();
    exp_q.push_back(32'h404);
    exp_q.push_back(32'h104);
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b0, 1'b1, 32'h0);
      #1;
      exp_v = exp_q.pop_front();
      tests_run++;
      if (ras_target !== exp_v) begin tests_failed++; $display("FAIL rp_pop%0d: got %h want %h", i, ras_target, exp_v); end
      tick();
    end
    clr();
    #1;
    tests_run++;
    if (ras_empty !== 1'b1) begin tests_failed++; $display("FAIL rp_empty: got %b want 1", ras_empty); end
    // call+ret on an empty stack acts as a push; invalid pre-decode is ignored
    set_in(1'b1, 1'b1, 1'b1, 32'h500);
    tick();
    set_in(1'b0, 1'b1, 1'b0, 32'h700);
    tick();
    set_in(1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    clr();
    #1;
    tests_run++;
    if (ras_target !== 32'h504 || ras_empty !== 1'b0) begin
      tests_failed++; $display("FAIL rp_empty_push: target %h empty %b want 00000504 0", ras_target, ras_empty);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 5; k++) push_call(32'h2000 + 32'h10 * k);
    #1;
    tests_run++;
    if (ras_target !== 32'h2044) begin tests_failed++; $display("FAIL ar_pre: got %h want 00002044", ras_target); end
    set_in(1'b1, 1'b0, 1'b1, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
      tests_failed++; $display("FAIL ar_flags: empty %b full %b want 1 0", ras_empty, ras_full);
    end
    tests_run++;
    if (ras_target !== 32'h0 || ras_hit !== 1'b0) begin
      tests_failed++; $display("FAIL ar_outputs: target %h hit %b want 0 0", ras_target, ras_hit);
    end
    tick();
    rst = 1'b0;
    clr();
    tick();
  endtask

  task automatic test_random();
    logic [2:0]    top;
    logic [2:0]    n_csp;
    logic [3:0]    n_ccnt;
    logic          v, c, r, cc, cr, fl;
    logic [AW-1:0] pc;
    do_reset();
    for (int i = 0; i < D; i++) m_ent[i] = 32'h0;
    m_sp = 3'd0; m_cnt = 4'd0; c_sp = 3'd0; c_cnt = 4'd0;
    for (int n = 0; n < 300; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      c  = $urandom_range(0, 1) == 1;
      r  = $urandom_range(0, 1) == 1;
      cc = ($urandom_range(0, 3) == 0);
      cr = ($urandom_range(0, 3) == 0) && (c_cnt != 4'd0);
      fl = ($urandom_range(0, 7) == 0);
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      set_in(v, c, r, pc);
      commit_call = cc;
      commit_ret  = cr;
      flush       = fl;
      #1;
      top = m_sp - 3'd1;
      exp_q.push_back((m_cnt == 4'd0) ? 32'h0 : m_ent[top]);
      exp_v = exp_q.pop_front();
      tests_run++;
      if (ras_target !== exp_v) begin tests_failed++; $display("FAIL rnd_target@%0d: got %h want %h", n, ras_target, exp_v); end
      tests_run++;
      if (ras_hit !== (v && r && (m_cnt != 4'd0))) begin tests_failed++; $display("FAIL rnd_hit@%0d: got %b", n, ras_hit); end
      tests_run++;
      if (ras_empty !== (m_cnt == 4'd0) || ras_full !== (m_cnt == 4'd8)) begin
        tests_failed++; $display("FAIL rnd_flags@%0d: empty %b full %b model cnt %0d", n, ras_empty, ras_full, m_cnt);
      end
      tick();
      // model update for the edge just taken
      n_csp = c_sp; n_ccnt = c_cnt;
      if (cc && !cr) begin
        n_csp = c_sp + 3'd1;
        n_ccnt = (c_cnt == 4'd8) ? c_cnt : c_cnt + 4'd1;
      end else if (cr && !cc && c_cnt != 4'd0) begin
        n_csp = c_sp - 3'd1;
        n_ccnt = c_cnt - 4'd1;
      end
      if (fl) begin
        m_sp = n_csp; m_cnt = n_ccnt;
      end else if (v && c && r && m_cnt != 4'd0) begin
        m_ent[top] = pc + 32'd4;
      end else if (v && c) begin
        m_ent[m_sp] = pc + 32'd4;
        m_sp = m_sp + 3'd1;
        m_cnt = (m_cnt == 4'd8) ? m_cnt : m_cnt + 4'd1;
      end else if (v && r && m_cnt != 4'd0) begin
        m_sp = m_sp - 3'd1;
        m_cnt = m_cnt - 4'd1;
      end
      c_sp = n_csp; c_cnt = n_ccnt;
    end
    clr();
  endtask

  initial begin
    rst = 1'b0;
    clr();
    test_reset();
    test_push_pop();
    test_overflow();
    test_flush();
    test_flush_commit();
    test_replace();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
